// File: rtl/conv_controller.sv
// conv_controller: sequences weight load, input-row priming, column sweep,
// adder drain and row write-back for the convolution datapath.
// Optional feature macro: CONV_CTRL_MULTI_IMAGE_EN streams consecutive images
// with one weight load until a 16'hFFFF nrows marker is read.
module conv_controller (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        dut_run,
  input  logic        dut_busy,
  input  logic [15:0] sram_dut_read_data,
  input  logic        last_col_next,
  input  logic        last_row_flag,
  input  logic        conv_go_flag,
  input  logic        initialization_flag,
  output logic        dut_busy_toggle,
  output logic        str_weights_dims,
  output logic        str_weights_data,
  output logic        rst_dut_wmem_read_address,
  output logic        str_input_nrows,
  output logic        str_input_ncols,
  output logic        incr_raddr_enable,
  output logic        pln_input_row_enable,
  output logic        incr_col_enable,
  output logic        rst_col_counter,
  output logic        incr_row_enable,
  output logic        rst_row_counter,
  output logic        update_d_in,
  output logic        toggle_conv_go_flag,
  output logic        str_temp_to_write,
  output logic        rst_output_row_temp,
  output logic        set_initialization_flag,
  output logic        rst_initialization_flag,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    W_DIM    = 4'd1,
    W_DATA   = 4'd2,
    R_ROWS   = 4'd3,
    R_COLS   = 4'd4,
    PRIME    = 4'd5,
    SWEEP    = 4'd6,
    DRAIN    = 4'd7,
    WRITE    = 4'd8,
    NEXT_ROW = 4'd9,
    FINISH   = 4'd10
  } state_t;

  state_t     state_q;
  logic [1:0] cnt_q;
  logic       first_q;
  logic       unused_flags;

  // The datapath flags are mirrored by the datapath itself; the sequence does not depend on them.
  assign unused_flags = conv_go_flag ^ initialization_flag;
  assign state_out    = state_q;

  // Single-process FSM: every strobe is registered from the decision made in the current state.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q                   <= IDLE;
      cnt_q                     <= 2'd0;
      first_q                   <= 1'b0;
      dut_busy_toggle           <= 1'b0;
      str_weights_dims          <= 1'b0;
      str_weights_data          <= 1'b0;
      rst_dut_wmem_read_address <= 1'b0;
      str_input_nrows           <= 1'b0;
      str_input_ncols           <= 1'b0;
      incr_raddr_enable         <= 1'b0;
      pln_input_row_enable      <= 1'b0;
      incr_col_enable           <= 1'b0;
      rst_col_counter           <= 1'b0;
      incr_row_enable           <= 1'b0;
      rst_row_counter           <= 1'b0;
      update_d_in               <= 1'b0;
      toggle_conv_go_flag       <= 1'b0;
      str_temp_to_write         <= 1'b0;
      rst_output_row_temp       <= 1'b0;
      set_initialization_flag   <= 1'b0;
      rst_initialization_flag   <= 1'b0;
    end else begin
      dut_busy_toggle           <= 1'b0;
      str_weights_dims          <= 1'b0;
      str_weights_data          <= 1'b0;
      rst_dut_wmem_read_address <= 1'b0;
      str_input_nrows           <= 1'b0;
      str_input_ncols           <= 1'b0;
      incr_raddr_enable         <= 1'b0;
      pln_input_row_enable      <= 1'b0;
      incr_col_enable           <= 1'b0;
      rst_col_counter           <= 1'b0;
      incr_row_enable           <= 1'b0;
      rst_row_counter           <= 1'b0;
      update_d_in               <= 1'b0;
      toggle_conv_go_flag       <= 1'b0;
      str_temp_to_write         <= 1'b0;
      rst_output_row_temp       <= 1'b0;
      set_initialization_flag   <= 1'b0;
      rst_initialization_flag   <= 1'b0;
      case (state_q)
        IDLE: if (dut_run && !dut_busy) begin
          dut_busy_toggle <= 1'b1;
          rst_col_counter <= 1'b1;
          rst_row_counter <= 1'b1;
          state_q         <= W_DIM;
        end
        W_DIM: begin
          str_weights_dims          <= 1'b1;
          rst_dut_wmem_read_address <= 1'b1;
          state_q                   <= W_DATA;
        end
        W_DATA: begin
          str_weights_data  <= 1'b1;
          incr_raddr_enable <= 1'b1;
          state_q           <= R_ROWS;
        end
        R_ROWS: begin
          str_input_nrows   <= 1'b1;
          incr_raddr_enable <= 1'b1;
          state_q           <= (sram_dut_read_data == 16'hFFFF) ? FINISH : R_COLS;
        end
        R_COLS: begin
          str_input_ncols   <= 1'b1;
          incr_raddr_enable <= 1'b1;
          cnt_q             <= 2'd0;
          state_q           <= PRIME;
        end
        PRIME: begin
          pln_input_row_enable <= 1'b1;
          incr_raddr_enable    <= 1'b1;
          if (cnt_q == 2'd2) begin
            set_initialization_flag <= 1'b1;
            cnt_q                   <= 2'd0;
            first_q                 <= 1'b1;
            state_q                 <= SWEEP;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        SWEEP: begin
          update_d_in         <= 1'b1;
          incr_col_enable     <= 1'b1;
          toggle_conv_go_flag <= first_q;
          rst_output_row_temp <= first_q;
          first_q             <= 1'b0;
          if (last_col_next) begin
            cnt_q   <= 2'd0;
            state_q <= DRAIN;
          end
        end
        DRAIN: if (cnt_q == 2'd1) begin
          toggle_conv_go_flag <= 1'b1;
          cnt_q               <= 2'd0;
          state_q             <= WRITE;
        end else begin
          cnt_q <= cnt_q + 2'd1;
        end
        WRITE: begin
          str_temp_to_write <= 1'b1;
          state_q           <= NEXT_ROW;
        end
        NEXT_ROW: begin
          rst_col_counter <= 1'b1;
          incr_row_enable <= 1'b1;
          if (last_row_flag) begin
`ifdef CONV_CTRL_MULTI_IMAGE_EN
            rst_row_counter <= 1'b1;
            state_q         <= R_ROWS;
`else
            state_q         <= FINISH;
`endif
          end else begin
            pln_input_row_enable <= 1'b1;
            incr_raddr_enable    <= 1'b1;
            first_q              <= 1'b1;
            state_q              <= SWEEP;
          end
        end
        FINISH: begin
          dut_busy_toggle         <= 1'b1;
          rst_initialization_flag <= 1'b1;
          state_q                 <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_controller.sv
// tb_conv_controller: scoreboard bench with a behavioural datapath model around conv_controller.
module tb_conv_controller;

`ifdef CONV_CTRL_MULTI_IMAGE_EN
  localparam int MULTI = 1;
`else
  localparam int MULTI = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        dut_run = 1'b0;
  logic        dut_busy;
  logic [15:0] sram_dut_read_data;
  logic        last_col_next, last_row_flag, conv_go_flag, initialization_flag;
  logic        dut_busy_toggle, str_weights_dims, str_weights_data, rst_dut_wmem_read_address;
  logic        str_input_nrows, str_input_ncols, incr_raddr_enable, pln_input_row_enable;
  logic        incr_col_enable, rst_col_counter, incr_row_enable, rst_row_counter;
  logic        update_d_in, toggle_conv_go_flag, str_temp_to_write, rst_output_row_temp;
  logic        set_initialization_flag, rst_initialization_flag;
  logic [3:0]  state_out;
  logic [17:0] outs;

  conv_controller dut (
    .clk(clk), .reset_b(reset_b), .dut_run(dut_run), .dut_busy(dut_busy),
    .sram_dut_read_data(sram_dut_read_data), .last_col_next(last_col_next),
    .last_row_flag(last_row_flag), .conv_go_flag(conv_go_flag),
    .initialization_flag(initialization_flag), .dut_busy_toggle(dut_busy_toggle),
    .str_weights_dims(str_weights_dims), .str_weights_data(str_weights_data),
    .rst_dut_wmem_read_address(rst_dut_wmem_read_address), .str_input_nrows(str_input_nrows),
    .str_input_ncols(str_input_ncols), .incr_raddr_enable(incr_raddr_enable),
    .pln_input_row_enable(pln_input_row_enable), .incr_col_enable(incr_col_enable),
    .rst_col_counter(rst_col_counter), .incr_row_enable(incr_row_enable),
    .rst_row_counter(rst_row_counter), .update_d_in(update_d_in),
    .toggle_conv_go_flag(toggle_conv_go_flag), .str_temp_to_write(str_temp_to_write),
    .rst_output_row_temp(rst_output_row_temp), .set_initialization_flag(set_initialization_flag),
    .rst_initialization_flag(rst_initialization_flag), .state_out(state_out)
  );

  always #5 clk = ~clk;

  assign outs = {dut_busy_toggle, str_weights_dims, str_weights_data, rst_dut_wmem_read_address,
                 str_input_nrows, str_input_ncols, incr_raddr_enable, pln_input_row_enable,
                 incr_col_enable, rst_col_counter, incr_row_enable, rst_row_counter,
                 update_d_in, toggle_conv_go_flag, str_temp_to_write, rst_output_row_temp,
                 set_initialization_flag, rst_initialization_flag};

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Datapath model: busy TFF, counters, flags and an SRAM returning dim or the end marker.
  int   dim = 4, nimg = 1;
  int   col, row, img;
  logic busy_q, go_q, init_q;
  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      busy_q <= 1'b0; go_q <= 1'b0; init_q <= 1'b0; col <= 0; row <= 0; img <= 0;
    end else begin
      if (dut_busy_toggle) busy_q <= ~busy_q;
      if (toggle_conv_go_flag) go_q <= ~go_q;
      if (set_initialization_flag) init_q <= 1'b1;
      else if (rst_initialization_flag) init_q <= 1'b0;
      if (rst_col_counter) col <= 0;
      else if (incr_col_enable) col <= col + 1;
      if (rst_row_counter) row <= 0;
      else if (incr_row_enable) row <= row + 1;
      if (dut_busy_toggle && !busy_q) img <= 0;
      else if (str_input_nrows) img <= img + 1;
    end
  end
  assign dut_busy            = busy_q;
  assign conv_go_flag        = go_q;
  assign initialization_flag = init_q;
  assign last_col_next       = (col == dim - 3);
  assign last_row_flag       = (row == dim - 3);
  assign sram_dut_read_data  = (img >= nimg) ? 16'hFFFF : 16'(dim);

  // Scoreboard entries: kind 0 = write (a = expected row), kind 1 = end of busy period.
  typedef struct {int kind; int a; int b; int c; int d;} exp_t;
  exp_t q[$];

  task automatic push_w(input int r);
    q.push_back('{0, r, 0, 0, 0});
  endtask

  task automatic push_done(input int wr, input int wl, input int nr, input int lat);
    q.push_back('{1, wr, wl, nr, lat});
  endtask

  // Monitor: pops an expectation on every write pulse and on every busy falling edge.
  int   cyc = 0, n_tog = 0, n_wl = 0, n_nr = 0, n_wr = 0, run_cyc = 0, last_wr = -100;
  logic busy_prev = 1'b0, wr_prev = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (!reset_b) begin
      n_tog = 0; n_wl = 0; n_nr = 0; n_wr = 0; busy_prev = 1'b0; wr_prev = 1'b0;
    end else begin
      cyc++;
      if (dut_run && !dut_busy && state_out == 4'd0) run_cyc = cyc;
      n_tog += int'(dut_busy_toggle);
      n_wl  += int'(str_weights_dims);
      n_nr  += int'(str_input_nrows);
      if (dut_busy_toggle || str_temp_to_write || toggle_conv_go_flag)
        check("exclusive_pulse", $countones({dut_busy_toggle, str_temp_to_write, toggle_conv_go_flag}), 1);
      if (wr_prev) check("write_width", int'(str_temp_to_write), 0);
      if (str_temp_to_write) begin
        if (dim >= 8) check("write_gap_ge8", int'(cyc - last_wr >= 8), 1);
        last_wr = cyc;
        n_wr++;
        check("write_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("write_kind", 0, e.kind);
          check("write_row", row, e.a);
        end
      end
      if (busy_prev && !dut_busy) begin
        check("done_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("done_kind", 1, e.kind);
          check("done_writes", n_wr, e.a);
          check("done_weight_loads", n_wl, e.b);
          check("done_nrows_reads", n_nr, e.c);
          check("done_busy_toggles", n_tog, 2);
          check("done_state_idle", int'(state_out), 0);
          check("done_latency_ok", int'(cyc - run_cyc <= e.d), 1);
        end
        n_tog = 0; n_wl = 0; n_nr = 0; n_wr = 0;
      end
      busy_prev = dut_busy;
      wr_prev   = str_temp_to_write;
    end
  end

  task automatic start(input int d, input int ni);
    dim  = d;
    nimg = ni;
    @(posedge clk); #1 dut_run = 1'b1;
    @(posedge clk); #1 dut_run = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    check(name, q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", int'(state_out), 0);
    check("reset_outputs", int'(outs), 0);
    check("reset_busy", int'(dut_busy), 0);
    @(posedge clk); #1 reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // 4x4 image, one image; a second dut_run while busy must be ignored.
    push_w(0); push_w(1);
    push_done(2, 1, 1 + MULTI, 1000);
    start(4, 1);
    repeat (3) @(negedge clk);
    check("busy_high", int'(dut_busy), 1);
    @(posedge clk); #1 dut_run = 1'b1;
    @(posedge clk); #1 dut_run = 1'b0;
    @(negedge clk);
    check("run_ignored_state", int'(state_out == 4'd1), 0);
    wait_done("img4x4_complete", 300);
    check("idle_after_4x4", int'(state_out), 0);
    check("busy_low_after_4x4", int'(dut_busy), 0);

    // End marker as first nrows word: no writes, short busy period.
    push_done(0, 1, 1, 8);
    start(4, 0);
    wait_done("marker_complete", 50);

    // 8x8 image: six well-separated single-cycle writes.
    for (int r = 0; r < 6; r++) push_w(r);
    push_done(6, 1, 1 + MULTI, 1000);
    start(8, 1);
    wait_done("img8x8_complete", 400);

    // Two 4x4 images queued before the marker; only the multi-image build processes both.
    for (int k = 0; k <= MULTI; k++) begin
      push_w(0); push_w(1);
    end
    push_done(2 + 2 * MULTI, 1, 1 + 2 * MULTI, 1000);
    start(4, 2);
    wait_done("two_images_complete", 400);

    // Asynchronous reset in the middle of a sweep.
    start(8, 1);
    begin
      int i;
      for (i = 0; i < 60 && state_out != 4'd6; i++) @(negedge clk);
      check("reached_sweep", int'(state_out), 6);
    end
    @(posedge clk); #2 reset_b = 1'b0;
    #1;
    check("midrun_reset_state", int'(state_out), 0);
    check("midrun_reset_outputs", int'(outs), 0);
    repeat (2) @(posedge clk);
    #1 reset_b = 1'b1;
    repeat (10) @(negedge clk);
    check("no_toggle_after_reset", n_tog, 0);
    check("idle_after_reset", int'(state_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/conv_controller.md
CONV_CONTROLLER -- requirements
Module: conv_controller

Interface
REQ-001 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-002 SHALL have port reset_b, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port dut_run, input, 1: start request, single-cycle pulse, sampled in IDLE only.
REQ-004 SHALL have port dut_busy, input, 1: busy flag fed back from the datapath TFF.
REQ-005 SHALL have port sram_dut_read_data, input, 16: input SRAM data, valid 1 cycle after address change.
REQ-006 SHALL have ports last_col_next, last_row_flag, conv_go_flag, initialization_flag, each input, 1: datapath status.
REQ-007 SHALL have port dut_busy_toggle, output, 1: one-cycle pulse that flips dut_busy.
REQ-008 SHALL have ports str_weights_dims, str_weights_data, rst_dut_wmem_read_address, each output, 1: weight-load strobes.
REQ-009 SHALL have ports str_input_nrows, str_input_ncols, incr_raddr_enable, pln_input_row_enable, each output, 1: input-read strobes.
REQ-010 SHALL have ports incr_col_enable, rst_col_counter, incr_row_enable, rst_row_counter, each output, 1: counter control.
REQ-011 SHALL have ports update_d_in, toggle_conv_go_flag, str_temp_to_write, rst_output_row_temp, set_initialization_flag, rst_initialization_flag, each output, 1.
REQ-012 SHALL have port state_out, output, 4: current FSM state encoding, for debug.

Function
REQ-013 SHALL implement states IDLE=0, W_DIM=1, W_DATA=2, R_ROWS=3, R_COLS=4, PRIME=5, SWEEP=6, DRAIN=7, WRITE=8, NEXT_ROW=9, FINISH=10; all other encodings SHALL go to IDLE.
REQ-014 IDLE: when dut_run=1 and dut_busy=0, SHALL assert dut_busy_toggle, rst_col_counter and rst_row_counter for 1 cycle and go to W_DIM; dut_run while dut_busy=1 SHALL be ignored.
REQ-015 W_DIM: SHALL assert str_weights_dims and rst_dut_wmem_read_address for 1 cycle, then go to W_DATA.
REQ-016 W_DATA: SHALL assert str_weights_data for 1 cycle, then go to R_ROWS with incr_raddr_enable pulsed.
REQ-017 R_ROWS: SHALL assert str_input_nrows and incr_raddr_enable; if sram_dut_read_data==16'hFFFF, SHALL go to FINISH without any write.
REQ-018 R_COLS: SHALL assert str_input_ncols and incr_raddr_enable, then go to PRIME.
REQ-019 PRIME: SHALL assert pln_input_row_enable and incr_raddr_enable for exactly 3 consecutive cycles (internal 2-bit counter), assert set_initialization_flag in the third cycle, then go to SWEEP.
REQ-020 SWEEP: SHALL assert update_d_in and incr_col_enable every cycle; on the first SWEEP cycle of a row SHALL pulse toggle_conv_go_flag and rst_output_row_temp; SHALL leave when last_col_next=1.
REQ-021 DRAIN: SHALL hold for exactly 2 cycles (adder pipeline depth), then pulse toggle_conv_go_flag and go to WRITE.
REQ-022 WRITE: SHALL assert str_temp_to_write for exactly 1 cycle (datapath write enable fires on its falling edge), then go to NEXT_ROW.
REQ-023 NEXT_ROW: SHALL pulse rst_col_counter and incr_row_enable; if last_row_flag=1, go to FINISH; else pulse pln_input_row_enable and incr_raddr_enable and go to SWEEP.
REQ-024 FINISH: SHALL pulse dut_busy_toggle and rst_initialization_flag, then go to IDLE.
REQ-025 All outputs SHALL be registered Moore decodes of state, asserting 1 cycle after the state is entered; no output SHALL be combinational from inputs.
REQ-026 Never more than one of dut_busy_toggle, str_temp_to_write, toggle_conv_go_flag SHALL assert in the same cycle.

Reset
REQ-027 reset_b=0 SHALL force IDLE, the PRIME counter to 0 and every output to 0 asynchronously, including mid-operation; after release, the block SHALL wait for a new dut_run.

Configuration
REQ-028 With CONV_CTRL_MULTI_IMAGE_EN defined, FINISH SHALL be reached only via the 16'hFFFF marker; after the last row, NEXT_ROW SHALL go to R_ROWS with rst_row_counter pulsed; weights SHALL not be reloaded.
REQ-029 Without CONV_CTRL_MULTI_IMAGE_EN, NEXT_ROW with last_row_flag=1 SHALL go to FINISH after one image.

Verification
REQ-030 Reset mid-SWEEP -> all outputs 0 and state_out=0 in the same cycle; dut_busy_toggle stays 0 after release.
REQ-031 3x3 weights, 4x4 image, dut_run pulse -> dut_busy high, exactly 2 str_temp_to_write pulses, dut_busy low, state_out=0.
REQ-032 dut_run pulse while dut_busy=1 -> no dut_busy_toggle, state unchanged.
REQ-033 First nrows word 16'hFFFF -> zero str_temp_to_write pulses; dut_busy returns to 0 within 8 cycles of dut_run.
REQ-034 8x8 image -> 6 writes, each str_temp_to_write exactly 1 cycle wide, separated by at least 8 cycles.
REQ-035 Macro defined: two 4x4 images, then 16'hFFFF -> 4 writes, weights strobes once, one busy period.
